stopwatch_ctrl: RTL and testbench

- Control FSM and carry scheduler for the stopwatch's four T-flip-flop BCD digit counters (MM:SS; d0 = seconds ones, d3 = minutes tens).
- Turns the start/stop and clear buttons into run/pause/clear states.
- Prescales the system clock into a 1 s tick.
- Issues one-cycle per-digit count-enable and clear strobes so that plain mod-10 digit counters form a 00:00–59:59 count chain; the tens digits are wrapped at 5 by clear strobes.

---
 rtl/stopwatch_if.sv | 40 ++++
 rtl/stopwatch_ctrl.sv | 119 +++++++++++
 tb/tb_stopwatch_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_if.sv
// Stopwatch controller signal bundle.
// Buttons and digit values in, strobes and status out.
interface stopwatch_if;
  logic       btn_start_stop;
  logic       btn_clear;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] dig_en;
  logic [3:0] dig_clr;
  logic       running;
  logic       ovf;

  modport master (
    output btn_start_stop,
    output btn_clear,
    output d0,
    output d1,
    output d2,
    output d3,
    input  dig_en,
    input  dig_clr,
    input  running,
    input  ovf
  );

  modport slave (
    input  btn_start_stop,
    input  btn_clear,
    input  d0,
    input  d1,
    input  d2,
    input  d3,
    output dig_en,
    output dig_clr,
    output running,
    output ovf
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear FSM, 1 s prescaler and carry scheduler
// for four external mod-10 BCD digit counters (MM:SS).
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  stopwatch_if.slave sw
);

  localparam int unsigned     PS_W   = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  state_e          state_q;
  state_e          state_d;
  logic            ss_q;
  logic            cl_q;
  logic [PS_W-1:0] ps_q;
  logic [PS_W-1:0] ps_d;
  logic [3:0]      en_q;
  logic [3:0]      en_d;
  logic [3:0]      clr_q;
  logic [3:0]      clr_d;
  logic            run_q;
  logic            ovf_q;
  logic            ovf_d;

  logic se;
  logic ce;
  logic tick;
  logic c0;
  logic c1;
  logic c2;
  logic c3;
  logic wrap;

  assign se = sw.btn_start_stop & ~ss_q;
  assign ce = sw.btn_clear & ~cl_q;

  assign tick = (state_q == RUN) && (ps_q == PS_MAX);

  // Out-of-range digits never match, so they simply never carry.
  assign c0   = tick;
  assign c1   = c0 & (sw.d0 == 4'd9);
  assign c2   = c1 & (sw.d1 == 4'd5);
  assign c3   = c2 & (sw.d2 == 4'd9);
  assign wrap = c3 & (sw.d3 == 4'd5);

  always_comb begin
    state_d = state_q;
    if (ce) begin
      state_d = IDLE;
    end else if (se) begin
      state_d = (state_q == RUN) ? PAUSE : RUN;
    end
  end

  always_comb begin
    ps_d = ps_q;
    if (ce || state_q == IDLE) begin
      ps_d = '0;
    end else if (state_q == RUN) begin
      ps_d = tick ? '0 : ps_q + PS_W'(1);
    end
  end

  always_comb begin
    en_d  = {c3 & (sw.d3 != 4'd5), c2,
             c1 & (sw.d1 != 4'd5), c0};
    clr_d = {c3 & (sw.d3 == 4'd5), 1'b0,
             c1 & (sw.d1 == 4'd5), 1'b0};
    ovf_d = ovf_q;
    if (wrap) begin
      en_d  = 4'b0000;
      clr_d = 4'b1111;
      ovf_d = 1'b1;
    end
    // A user clear beats any coincident tick.
    if (ce) begin
      en_d  = 4'b0000;
      clr_d = 4'b1111;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ss_q    <= 1'b0;
      cl_q    <= 1'b0;
      ps_q    <= '0;
      en_q    <= 4'b0000;
      clr_q   <= 4'b0000;
      run_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_q    <= sw.btn_start_stop;
      cl_q    <= sw.btn_clear;
      ps_q    <= ps_d;
      en_q    <= en_d;
      clr_q   <= clr_d;
      run_q   <= (state_d == RUN);
      ovf_q   <= ovf_d;
    end
  end

  assign sw.dig_en  = en_q;
  assign sw.dig_clr = clr_q;
  assign sw.running = run_q;
  assign sw.ovf     = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4 and
// a behavioural model of the four mod-10 digit counters.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] dm;
  logic        ld_en = 1'b0;
  logic [15:0] ld_val = 16'h0000;
  int          checks = 0;
  int          errors = 0;

  stopwatch_if sw();

  assign sw.d0 = dm[3:0];
  assign sw.d1 = dm[7:4];
  assign sw.d2 = dm[11:8];
  assign sw.d3 = dm[15:12];

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      dm <= 16'h0000;
    end else if (ld_en) begin
      dm <= ld_val;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sw.dig_clr[i])
          dm[i*4 +: 4] <= 4'd0;
        else if (sw.dig_en[i])
          dm[i*4 +: 4] <= (dm[i*4 +: 4] == 4'd9) ? 4'd0
                        : dm[i*4 +: 4] + 4'd1;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_clear();
    sw.btn_clear = 1'b1;
    step(1);
    sw.btn_clear = 1'b0;
    step(1);
  endtask

  task automatic preload(input logic [15:0] v);
    ld_val = v;
    ld_en  = 1'b1;
    step(1);
    ld_en  = 1'b0;
  endtask

  task automatic start_pulse();
    sw.btn_start_stop = 1'b1;
    step(1);
    sw.btn_start_stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sw.btn_start_stop = 1'b0;
    sw.btn_clear = 1'b0;
    step(3);
    rst = 1'b0;
    checks++;
    if (sw.dig_en !== 4'b0000) begin
      errors++;
      $display("FAIL reset_en got %b exp 0000", sw.dig_en);
    end
    checks++;
    if (sw.dig_clr !== 4'b0000) begin
      errors++;
      $display("FAIL reset_clr got %b exp 0000", sw.dig_clr);
    end
    checks++;
    if (sw.running !== 1'b0) begin
      errors++;
      $display("FAIL reset_running got %b exp 0", sw.running);
    end
    checks++;
    if (sw.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_ovf got %b exp 0", sw.ovf);
    end
  endtask

  task automatic test_count();
    logic [3:0] exp;
    start_pulse();
    checks++;
    if (sw.running !== 1'b1) begin
      errors++;
      $display("FAIL count_running got %b exp 1", sw.running);
    end
    for (int n = 2; n <= 41; n++) begin
      step(1);
      exp = 4'b0000;
      if (n >= 5 && n % 4 == 1)
        exp = (n == 41) ? 4'b0011 : 4'b0001;
      checks++;
      if (sw.dig_en !== exp) begin
        errors++;
        $display("FAIL count_en cyc %0d got %b exp %b",
                 n, sw.dig_en, exp);
      end
    end
    step(1);
    checks++;
    if (dm !== 16'h0010) begin
      errors++;
      $display("FAIL count_digits got %h exp 0010", dm);
    end
  endtask

  task automatic test_carry();
    do_clear();
    preload(16'h0059);
    start_pulse();
    step(4);
    checks++;
    if (sw.dig_en !== 4'b0101) begin
      errors++;
      $display("FAIL carry_en got %b exp 0101", sw.dig_en);
    end
    checks++;
    if (sw.dig_clr !== 4'b0010) begin
      errors++;
      $display("FAIL carry_clr got %b exp 0010", sw.dig_clr);
    end
    step(1);
    checks++;
    if (dm !== 16'h0100) begin
      errors++;
      $display("FAIL carry_digits got %h exp 0100", dm);
    end
  endtask

  task automatic test_overflow();
    do_clear();
    preload(16'h5959);
    start_pulse();
    step(4);
    checks++;
    if (sw.dig_en !== 4'b0000 || sw.dig_clr !== 4'b1111) begin
      errors++;
      $display("FAIL ovf_strobe got en %b clr %b exp 0000 1111",
               sw.dig_en, sw.dig_clr);
    end
    checks++;
    if (sw.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set got %b exp 1", sw.ovf);
    end
    step(1);
    checks++;
    if (dm !== 16'h0000) begin
      errors++;
      $display("FAIL ovf_digits got %h exp 0000", dm);
    end
    step(3);
    checks++;
    if (sw.dig_en !== 4'b0001 || sw.ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold got en %b ovf %b exp 0001 1",
               sw.dig_en, sw.ovf);
    end
    sw.btn_clear = 1'b1;
    step(1);
    sw.btn_clear = 1'b0;
    checks++;
    if (sw.ovf !== 1'b0 || sw.dig_clr !== 4'b1111) begin
      errors++;
      $display("FAIL ovf_clear got ovf %b clr %b exp 0 1111",
               sw.ovf, sw.dig_clr);
    end
    step(1);
  endtask

  task automatic test_pause();
    do_clear();
    start_pulse();
    step(1);
    start_pulse();
    checks++;
    if (sw.running !== 1'b0) begin
      errors++;
      $display("FAIL pause_running got %b exp 0", sw.running);
    end
    for (int n = 0; n < 20; n++) begin
      step(1);
      checks++;
      if (sw.dig_en !== 4'b0000 || sw.running !== 1'b0) begin
        errors++;
        $display("FAIL pause_hold cyc %0d got en %b run %b exp 0000 0",
                 n, sw.dig_en, sw.running);
      end
    end
    start_pulse();
    checks++;
    if (sw.running !== 1'b1) begin
      errors++;
      $display("FAIL resume_running got %b exp 1", sw.running);
    end
    for (int n = 1; n <= 2; n++) begin
      checks++;
      if (sw.dig_en !== 4'b0000) begin
        errors++;
        $display("FAIL resume_early cyc %0d got %b exp 0000",
                 n, sw.dig_en);
      end
      step(1);
    end
    checks++;
    if (sw.dig_en !== 4'b0001) begin
      errors++;
      $display("FAIL resume_tick got %b exp 0001", sw.dig_en);
    end
  endtask

  task automatic test_clear_start_collision();
    do_clear();
    start_pulse();
    step(4);
    checks++;
    if (sw.dig_en !== 4'b0001) begin
      errors++;
      $display("FAIL coll_pre got %b exp 0001", sw.dig_en);
    end
    step(3);
    sw.btn_start_stop = 1'b1;
    sw.btn_clear = 1'b1;
    step(1);
    sw.btn_start_stop = 1'b0;
    sw.btn_clear = 1'b0;
    checks++;
    if (sw.dig_en !== 4'b0000 || sw.dig_clr !== 4'b1111 ||
        sw.running !== 1'b0) begin
      errors++;
      $display("FAIL coll_clear got en %b clr %b run %b exp 0000 1111 0",
               sw.dig_en, sw.dig_clr, sw.running);
    end
    step(1);
    checks++;
    if (sw.dig_clr !== 4'b0000 || sw.dig_en !== 4'b0000) begin
      errors++;
      $display("FAIL coll_once got en %b clr %b exp 0000 0000",
               sw.dig_en, sw.dig_clr);
    end
    start_pulse();
    for (int n = 1; n <= 3; n++) begin
      step(1);
      checks++;
      if (sw.dig_en !== 4'b0000) begin
        errors++;
        $display("FAIL coll_ps cyc %0d got %b exp 0000", n, sw.dig_en);
      end
    end
    step(1);
    checks++;
    if (sw.dig_en !== 4'b0001) begin
      errors++;
      $display("FAIL coll_tick got %b exp 0001", sw.dig_en);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] exp;
    do_clear();
    start_pulse();
    step(4);
    checks++;
    if (sw.dig_en !== 4'b0001) begin
      errors++;
      $display("FAIL rstrun_pre got %b exp 0001", sw.dig_en);
    end
    step(3);
    rst = 1'b1;
    sw.btn_start_stop = 1'b1;
    step(1);
    rst = 1'b0;
    checks++;
    if (sw.dig_en !== 4'b0000 || sw.dig_clr !== 4'b0000 ||
        sw.running !== 1'b0 || sw.ovf !== 1'b0) begin
      errors++;
      $display("FAIL rstrun_out got en %b clr %b run %b ovf %b exp 0",
               sw.dig_en, sw.dig_clr, sw.running, sw.ovf);
    end
    for (int n = 10; n <= 15; n++) begin
      step(1);
      exp = (n == 14) ? 4'b0001 : 4'b0000;
      checks++;
      if (sw.running !== 1'b1 || sw.dig_en !== exp) begin
        errors++;
        $display("FAIL rstrun_held cyc %0d got run %b en %b exp 1 %b",
                 n, sw.running, sw.dig_en, exp);
      end
    end
    sw.btn_start_stop = 1'b0;
    step(1);
  endtask

  initial begin
    test_reset();
    test_count();
    test_carry();
    test_overflow();
    test_pause();
    test_clear_start_collision();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
